// File: rtl/txn_id_queue_if.sv
// Enqueue/dequeue handshake bundle between the AXI capture logic and txn_id_queue.
interface txn_id_queue_if #(
  parameter int IdWidth     = 4,
  parameter int LenWidth    = 8,
  parameter int BudgetWidth = 3,
  parameter int AccuWidth   = 10
);
  logic                   enq_valid_i;
  logic                   enq_ready_o;
  logic [IdWidth-1:0]     enq_id_i;
  logic [LenWidth-1:0]    enq_len_i;
  logic [BudgetWidth-1:0] budget_i;
  logic [AccuWidth-1:0]   accum_len_i;
  logic                   deq_valid_i;
  logic [IdWidth-1:0]     deq_id_i;
  logic                   deq_err_o;

  modport slave (
    input  enq_valid_i, enq_id_i, enq_len_i, budget_i, accum_len_i,
    input  deq_valid_i, deq_id_i,
    output enq_ready_o, deq_err_o
  );

  modport master (
    output enq_valid_i, enq_id_i, enq_len_i, budget_i, accum_len_i,
    output deq_valid_i, deq_id_i,
    input  enq_ready_o, deq_err_o
  );
endinterface

// File: rtl/txn_id_queue.sv
// Per-ID in-order transaction tracker: head/tail table plus linked-data store.
// Define TXN_ID_QUEUE_TIMEOUT_EN to add per-entry budget counters and timeout reporting.
module txn_id_queue #(
  parameter int MaxTxns      = 8,
  parameter int HtCapacity   = 4,
  parameter int IdWidth      = 4,
  parameter int LenWidth     = 8,
  parameter int BudgetWidth  = 3,
  parameter int AccuWidth    = 10,
  parameter int CntWidth     = 16,
  parameter int PrescalerDiv = 1
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  txn_id_queue_if.slave                  q_if,
  input  logic                           tick_i,
  output logic                           timeout_o,
  output logic [IdWidth-1:0]             timeout_id_o,
  output logic [$clog2(MaxTxns+1)-1:0]   occupancy_o,
  output logic                           full_o,
  output logic                           empty_o
);
  localparam int LIdxW = $clog2(MaxTxns);
  localparam int HIdxW = (HtCapacity > 1) ? $clog2(HtCapacity) : 1;
  localparam int OccW  = $clog2(MaxTxns + 1);

  typedef logic [LIdxW-1:0] lidx_t;
  typedef logic [HIdxW-1:0] hidx_t;

  logic [HtCapacity-1:0] ht_valid_q, ht_valid_d;
  logic [IdWidth-1:0]    ht_id_q   [HtCapacity];
  logic [IdWidth-1:0]    ht_id_d   [HtCapacity];
  lidx_t                 ht_head_q [HtCapacity];
  lidx_t                 ht_head_d [HtCapacity];
  lidx_t                 ht_tail_q [HtCapacity];
  lidx_t                 ht_tail_d [HtCapacity];

  logic [MaxTxns-1:0]    ld_valid_q, ld_valid_d;
  lidx_t                 ld_next_q [MaxTxns];
  lidx_t                 ld_next_d [MaxTxns];

  logic [OccW-1:0]       occ_q, occ_d;
  logic                  deq_err_q, deq_err_d;

  logic                  enq_hit, deq_hit;
  hidx_t                 enq_hidx, deq_hidx;
  logic                  ht_free_any, ld_free_any;
  lidx_t                 ld_free_idx;
  logic                  enq_ready, enq_fire, deq_fire;
  lidx_t                 deq_head;
  logic                  deq_last;
  hidx_t                 ht_alloc_idx;

  // Lookups on registered state only, so enq_ready has no path from the dequeue port.
  always_comb begin
    enq_hit     = 1'b0;
    enq_hidx    = '0;
    deq_hit     = 1'b0;
    deq_hidx    = '0;
    ld_free_idx = '0;
    for (int i = HtCapacity - 1; i >= 0; i--) begin
      if (ht_valid_q[i] && (ht_id_q[i] == q_if.enq_id_i)) begin
        enq_hit  = 1'b1;
        enq_hidx = hidx_t'(i);
      end
      if (ht_valid_q[i] && (ht_id_q[i] == q_if.deq_id_i)) begin
        deq_hit  = 1'b1;
        deq_hidx = hidx_t'(i);
      end
    end
    for (int i = MaxTxns - 1; i >= 0; i--) begin
      if (!ld_valid_q[i]) ld_free_idx = lidx_t'(i);
    end
  end

  assign ht_free_any = ~&ht_valid_q;
  assign ld_free_any = ~&ld_valid_q;
  assign enq_ready   = ld_free_any && (enq_hit || ht_free_any);
  assign enq_fire    = q_if.enq_valid_i && enq_ready;
  assign deq_fire    = q_if.deq_valid_i && deq_hit;
  assign deq_head    = ht_head_q[deq_hidx];
  assign deq_last    = (deq_head == ht_tail_q[deq_hidx]);

  // Dequeue first, then enqueue against the post-dequeue tables.
  always_comb begin
    ht_valid_d   = ht_valid_q;
    ht_id_d      = ht_id_q;
    ht_head_d    = ht_head_q;
    ht_tail_d    = ht_tail_q;
    ld_valid_d   = ld_valid_q;
    ld_next_d    = ld_next_q;
    ht_alloc_idx = '0;

    if (deq_fire) begin
      ld_valid_d[deq_head] = 1'b0;
      if (deq_last) ht_valid_d[deq_hidx] = 1'b0;
      else          ht_head_d[deq_hidx]  = ld_next_q[deq_head];
    end

    for (int i = HtCapacity - 1; i >= 0; i--) begin
      if (!ht_valid_d[i]) ht_alloc_idx = hidx_t'(i);
    end
    // An ID emptied by this cycle's dequeue keeps its slot for the re-enqueue.
    if (enq_hit) ht_alloc_idx = enq_hidx;

    if (enq_fire) begin
      ld_valid_d[ld_free_idx] = 1'b1;
      if (enq_hit && ht_valid_d[enq_hidx]) begin
        ld_next_d[ht_tail_q[enq_hidx]] = ld_free_idx;
        ht_tail_d[enq_hidx]            = ld_free_idx;
      end else begin
        ht_valid_d[ht_alloc_idx] = 1'b1;
        ht_id_d[ht_alloc_idx]    = q_if.enq_id_i;
        ht_head_d[ht_alloc_idx]  = ld_free_idx;
        ht_tail_d[ht_alloc_idx]  = ld_free_idx;
      end
    end
  end

  assign occ_d     = occ_q + OccW'(enq_fire) - OccW'(deq_fire);
  assign deq_err_d = q_if.deq_valid_i && !deq_hit;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ht_valid_q <= '0;
      ld_valid_q <= '0;
      occ_q      <= '0;
      deq_err_q  <= 1'b0;
      for (int i = 0; i < HtCapacity; i++) begin
        ht_id_q[i]   <= '0;
        ht_head_q[i] <= '0;
        ht_tail_q[i] <= '0;
      end
      for (int i = 0; i < MaxTxns; i++) begin
        ld_next_q[i] <= '0;
      end
    end else begin
      ht_valid_q <= ht_valid_d;
      ht_id_q    <= ht_id_d;
      ht_head_q  <= ht_head_d;
      ht_tail_q  <= ht_tail_d;
      ld_valid_q <= ld_valid_d;
      ld_next_q  <= ld_next_d;
      occ_q      <= occ_d;
      deq_err_q  <= deq_err_d;
    end
  end

  assign q_if.enq_ready_o = enq_ready;
  assign q_if.deq_err_o   = deq_err_q;
  assign occupancy_o      = occ_q;
  assign full_o           = (occ_q == OccW'(MaxTxns));
  assign empty_o          = (occ_q == '0);

`ifdef TXN_ID_QUEUE_TIMEOUT_EN
  localparam int SumW     = BudgetWidth + AccuWidth + LenWidth + 2;
  localparam int BW       = (SumW > CntWidth + 1) ? SumW : CntWidth + 1;
  localparam int PreShift = $clog2(PrescalerDiv);
  localparam logic [BW-1:0] CntMax = {{(BW - CntWidth){1'b0}}, {CntWidth{1'b1}}};

  logic [CntWidth-1:0] cnt_q [MaxTxns];
  logic [CntWidth-1:0] cnt_d [MaxTxns];
  logic [BW-1:0]       term_accum, term_burst, budget_wide;
  logic [CntWidth-1:0] budget_sat;

  // Arithmetic is wide enough that the sum never wraps before saturation.
  always_comb begin
    term_accum  = BW'(q_if.budget_i) * BW'(q_if.accum_len_i);
    term_burst  = (BW'(q_if.budget_i) * (BW'(q_if.enq_len_i) + BW'(1))) >> PreShift;
    budget_wide = term_accum + term_burst + BW'(1);
    budget_sat  = (budget_wide > CntMax) ? '1 : budget_wide[CntWidth-1:0];
  end

  always_comb begin
    for (int i = 0; i < MaxTxns; i++) begin
      cnt_d[i] = cnt_q[i];
      if (tick_i && ld_valid_q[i] && (cnt_q[i] != '0)) cnt_d[i] = cnt_q[i] - CntWidth'(1);
    end
    if (enq_fire) cnt_d[ld_free_idx] = budget_sat;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < MaxTxns; i++) cnt_q[i] <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    timeout_o    = 1'b0;
    timeout_id_o = '0;
    for (int i = HtCapacity - 1; i >= 0; i--) begin
      if (ht_valid_q[i] && (cnt_q[ht_head_q[i]] == '0)) begin
        timeout_o    = 1'b1;
        timeout_id_o = ht_id_q[i];
      end
    end
  end
`else
  logic                unused_inputs;
  logic [CntWidth-1:0] unused_cfg;

  assign unused_inputs = ^{tick_i, q_if.budget_i, q_if.accum_len_i, q_if.enq_len_i};
  assign unused_cfg    = CntWidth'(PrescalerDiv);
  assign timeout_o     = 1'b0;
  assign timeout_id_o  = '0;
`endif

endmodule

// File: tb/tb_txn_id_queue.sv
// Scoreboard bench for txn_id_queue: stimulus queues expected status, a monitor checks it.
module tb_txn_id_queue;
  localparam int MaxTxns      = 8;
  localparam int HtCapacity   = 4;
  localparam int IdWidth      = 4;
  localparam int LenWidth     = 8;
  localparam int BudgetWidth  = 3;
  localparam int AccuWidth    = 10;
  localparam int CntWidth     = 10;
  localparam int PrescalerDiv = 1;
`ifdef TXN_ID_QUEUE_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic         clk  = 1'b0;
  logic         rst  = 1'b1;
  logic         tick = 1'b0;
  logic         timeout;
  logic [3:0]   timeout_id;
  logic [3:0]   occupancy;
  logic         full, empty;

  txn_id_queue_if #(.IdWidth(IdWidth), .LenWidth(LenWidth),
                    .BudgetWidth(BudgetWidth), .AccuWidth(AccuWidth)) q_if ();

  txn_id_queue #(
    .MaxTxns(MaxTxns), .HtCapacity(HtCapacity), .IdWidth(IdWidth), .LenWidth(LenWidth),
    .BudgetWidth(BudgetWidth), .AccuWidth(AccuWidth), .CntWidth(CntWidth),
    .PrescalerDiv(PrescalerDiv)
  ) dut (
    .clk_i(clk), .rst_i(rst), .q_if(q_if), .tick_i(tick),
    .timeout_o(timeout), .timeout_id_o(timeout_id),
    .occupancy_o(occupancy), .full_o(full), .empty_o(empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    string name;
    int    occ;
    bit    ready;
    bit    err;
    bit    tout;
    int    tid;
    bit    quiet;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string nm, input int act, input int exp_v);
    n_cmp++;
    if (act != exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp_v);
    end
  endtask

  // Monitor: whenever the DUT takes a handshake, dequeue or tick, check the status that follows.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      if (!rst && ((q_if.enq_valid_i && q_if.enq_ready_o) || q_if.deq_valid_i || tick)) begin
        @(negedge clk);
        if (sb_q.size() == 0) begin
          chk("unexpected_txn", 1, 0);
        end else begin
          e = sb_q.pop_front();
          chk({e.name, "_occ"},   int'(occupancy),        e.occ);
          chk({e.name, "_full"},  int'(full),             int'(e.occ == MaxTxns));
          chk({e.name, "_empty"}, int'(empty),            int'(e.occ == 0));
          chk({e.name, "_ready"}, int'(q_if.enq_ready_o), int'(e.ready));
          chk({e.name, "_err"},   int'(q_if.deq_err_o),   int'(e.err));
          chk({e.name, "_tout"},  int'(timeout),          int'(e.tout));
          chk({e.name, "_tid"},   int'(timeout_id),       e.tid);
          if (!e.quiet)
            $display("txn %-14s occ=%0d full=%0b empty=%0b ready=%0b err=%0b tout=%0b tid=%0d",
                     e.name, occupancy, full, empty, q_if.enq_ready_o, q_if.deq_err_o,
                     timeout, timeout_id);
        end
      end
    end
  end

  task automatic op(input string nm, input bit ev, input int eid, input int elen,
                    input int ebud, input int eacc, input bit dv, input int did, input bit tk,
                    input int e_occ, input bit e_ready, input bit e_err, input bit e_tout,
                    input int e_tid, input bit quiet);
    exp_t e;
    q_if.enq_valid_i = ev;
    if (ev) begin
      q_if.enq_id_i    = IdWidth'(eid);
      q_if.enq_len_i   = LenWidth'(elen);
      q_if.budget_i    = BudgetWidth'(ebud);
      q_if.accum_len_i = AccuWidth'(eacc);
    end
    q_if.deq_valid_i = dv;
    q_if.deq_id_i    = IdWidth'(did);
    tick             = tk;
    e.name  = nm;
    e.occ   = e_occ;
    e.ready = e_ready;
    e.err   = e_err;
    e.tout  = TO_EN && e_tout;
    e.tid   = TO_EN ? e_tid : 0;
    e.quiet = quiet;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    q_if.enq_valid_i = 1'b0;
    q_if.deq_valid_i = 1'b0;
    tick             = 1'b0;
    @(negedge clk);
    #1;
  endtask

  task automatic enq(input string nm, input int id, input int len, input int bud,
                     input int acc, input int e_occ, input bit e_ready);
    op(nm, 1'b1, id, len, bud, acc, 1'b0, 0, 1'b0, e_occ, e_ready, 1'b0, 1'b0, 0, 1'b0);
  endtask

  task automatic deq(input string nm, input int id, input int e_occ, input bit e_ready,
                     input bit e_err, input bit e_tout, input int e_tid);
    op(nm, 1'b0, 0, 0, 0, 0, 1'b1, id, 1'b0, e_occ, e_ready, e_err, e_tout, e_tid, 1'b0);
  endtask

  task automatic tk(input string nm, input int e_occ, input bit e_ready, input bit e_tout,
                    input int e_tid, input bit quiet);
    op(nm, 1'b0, 0, 0, 0, 0, 1'b0, 0, 1'b1, e_occ, e_ready, 1'b0, e_tout, e_tid, quiet);
  endtask

  // Asynchronous reset: outputs must be at reset values before any clock edge.
  task automatic do_reset(input string nm);
    rst = 1'b1;
    #2;
    chk({nm, "_occ"},   int'(occupancy),        0);
    chk({nm, "_empty"}, int'(empty),            1);
    chk({nm, "_full"},  int'(full),             0);
    chk({nm, "_ready"}, int'(q_if.enq_ready_o), 1);
    chk({nm, "_err"},   int'(q_if.deq_err_o),   0);
    chk({nm, "_tout"},  int'(timeout),          0);
    chk({nm, "_tid"},   int'(timeout_id),       0);
    $display("txn %-14s reset applied", nm);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    q_if.enq_valid_i = 1'b0;
    q_if.enq_id_i    = '0;
    q_if.enq_len_i   = '0;
    q_if.budget_i    = '0;
    q_if.accum_len_i = '0;
    q_if.deq_valid_i = 1'b0;
    q_if.deq_id_i    = '0;
    repeat (2) @(posedge clk);
    #1;
    do_reset("por");

    // Budget 2*0 + 2*8 + 1 = 17: times out on the 17th tick.
    enq("enq3_c17", 3, 7, 2, 0, 1, 1'b1);
    for (int k = 1; k <= 17; k++)
      tk("tick17", 1, 1'b1, k == 17, (k == 17) ? 3 : 0, 1'b1);
    deq("deq3", 3, 0, 1'b1, 1'b0, 1'b0, 0);

    // Per-ID order: first id-1 budget 1, second 78, id-2 budget 102.
    enq("enq1_a", 1, 0, 0, 0, 1, 1'b1);
    enq("enq1_b", 1, 0, 7, 10, 2, 1'b1);
    enq("enq2", 2, 0, 1, 100, 3, 1'b1);
    deq("deq1_first", 1, 2, 1'b1, 1'b0, 1'b0, 0);
    tk("tick_order", 2, 1'b1, 1'b0, 0, 1'b0);
    deq("deq1_second", 1, 1, 1'b1, 1'b0, 1'b0, 0);
    deq("deq1_none", 1, 1, 1'b1, 1'b1, 1'b0, 0);

    // Fill all linked entries using four distinct IDs.
    enq("fill4", 4, 0, 0, 0, 2, 1'b1);
    enq("fill5", 5, 0, 0, 0, 3, 1'b1);
    enq("fill6", 6, 0, 0, 0, 4, 1'b1);
    q_if.enq_id_i = 4'd7;
    #1;
    chk("ht_full_ready", int'(q_if.enq_ready_o), 0);
    enq("fill2", 2, 0, 0, 0, 5, 1'b1);
    enq("fill4b", 4, 0, 0, 0, 6, 1'b1);
    enq("fill5b", 5, 0, 0, 0, 7, 1'b1);
    enq("fill6b", 6, 0, 0, 0, 8, 1'b0);
    deq("deq_after_full", 4, 7, 1'b1, 1'b0, 1'b0, 0);

    // Reset mid-operation, then same-cycle dequeue/enqueue of one ID.
    do_reset("rst_mid");
    enq("enq5", 5, 0, 0, 0, 1, 1'b1);
    op("simul5", 1'b1, 5, 0, 0, 0, 1'b1, 5, 1'b0, 1, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    enq("enq1", 1, 0, 0, 0, 2, 1'b1);
    enq("enq2", 2, 0, 0, 0, 3, 1'b1);
    enq("enq3", 3, 0, 0, 0, 4, 1'b1);
    q_if.enq_id_i = 4'd8;
    #1;
    chk("ht_reuse_ready", int'(q_if.enq_ready_o), 0);
    deq("deq5", 5, 3, 1'b1, 1'b0, 1'b0, 0);
    deq("deq5_none", 5, 3, 1'b1, 1'b1, 1'b0, 0);

    // Counter of 1 expires on a single tick; unknown-ID dequeue errors.
    do_reset("rst_to");
    enq("enq2_c1", 2, 0, 0, 0, 1, 1'b1);
    tk("tick_to", 1, 1'b1, 1'b1, 2, 1'b0);
    deq("deq9_err", 9, 1, 1'b1, 1'b1, 1'b1, 2);
    deq("deq2", 2, 0, 1'b1, 1'b0, 1'b0, 0);

    // 7*1023 + 7*256 + 1 exceeds 10 bits: counter saturates at 1023.
    enq("enq0_sat", 0, 255, 7, 1023, 1, 1'b1);
    for (int k = 1; k <= 1023; k++)
      tk("tick_sat", 1, 1'b1, k == 1023, 0, k != 1023);
    deq("deq0", 0, 0, 1'b1, 1'b0, 1'b0, 0);

    for (int k = 0; k < 20 && sb_q.size() != 0; k++) @(negedge clk);
    chk("sb_drain", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
